// File: rtl/asrm_mem_sequencer.sv
// asrm_mem_sequencer
// Turns one CPU load/store request into the command sequence for a
// word-wide synchronous RAM. Reduced-width stores become read-modify-write
// so the RAM bits above the effective width are preserved; loads are a
// timed read whose result is zero-extended from the effective width.
module asrm_mem_sequencer #(
  parameter int wordsize    = 16,
  parameter int ram_latency = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req,
  input  logic                we,
  input  logic [1:0]          size,
  input  logic [wordsize-1:0] addr,
  input  logic [wordsize-1:0] wdata,
  output logic                busy,
  output logic                ack,
  output logic [wordsize-1:0] rdata,
  output logic                ram_en,
  output logic                ram_wen,
  output logic [wordsize-1:0] ram_addr,
  output logic [wordsize-1:0] ram_wdata,
  input  logic [wordsize-1:0] ram_rdata
);

  typedef enum logic [2:0] {IDLE, RD_CMD, RD_WAIT, WR_CMD, ACK} state_t;

  state_t              state_reg;
  logic                we_reg;
  logic [1:0]          size_reg;
  logic [wordsize-1:0] wdata_reg;
  logic [1:0]          cnt_reg;
  logic                busy_reg;
  logic                ack_reg;
  logic                ram_en_reg;
  logic                ram_wen_reg;
  logic [wordsize-1:0] rdata_reg;
  logic [wordsize-1:0] ram_addr_reg;
  logic [wordsize-1:0] ram_wdata_reg;

  // A size code only narrows the access when it is narrower than the word;
  // otherwise the access behaves as a full-word one.
  function automatic int eff_width(input logic [1:0] s);
    int w;
    w = wordsize;
    case (s)
      2'b01:   if (wordsize > 32) w = 32;
      2'b10:   if (wordsize > 16) w = 16;
      2'b11:   if (wordsize > 8)  w = 8;
      default: w = wordsize;
    endcase
    return w;
  endfunction

  int                  req_width;
  int                  lat_width;
  logic [wordsize-1:0] req_mask;
  logic [wordsize-1:0] lat_mask;
  logic                req_reduced;

  assign req_width = eff_width(size);
  assign lat_width = eff_width(size_reg);

  // Low-bit masks: the incoming request's (for the IDLE branch decision)
  // and the accepted request's (for merge and zero-extension).
  genvar gi;
  generate
    for (gi = 0; gi < wordsize; gi++) begin : g_mask
      assign req_mask[gi] = (gi < req_width);
      assign lat_mask[gi] = (gi < lat_width);
    end
  endgenerate

  assign req_reduced = ~(&req_mask);

  // Sequencer FSM; every output is registered and set on the transition
  // into the state that owns it.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg     <= IDLE;
      we_reg        <= 1'b0;
      size_reg      <= 2'b00;
      wdata_reg     <= '0;
      cnt_reg       <= 2'd0;
      busy_reg      <= 1'b0;
      ack_reg       <= 1'b0;
      ram_en_reg    <= 1'b0;
      ram_wen_reg   <= 1'b0;
      rdata_reg     <= '0;
      ram_addr_reg  <= '0;
      ram_wdata_reg <= '0;
    end else begin
      ack_reg     <= 1'b0;
      ram_en_reg  <= 1'b0;
      ram_wen_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (req) begin
            we_reg       <= we;
            size_reg     <= size;
            wdata_reg    <= wdata;
            ram_addr_reg <= addr;
            busy_reg     <= 1'b1;
            ram_en_reg   <= 1'b1;
            if (we && !req_reduced) begin
              ram_wen_reg   <= 1'b1;
              ram_wdata_reg <= wdata;
              state_reg     <= WR_CMD;
            end else begin
              state_reg <= RD_CMD;
            end
          end
        end
        RD_CMD: begin
          cnt_reg   <= 2'(ram_latency - 1);
          state_reg <= RD_WAIT;
        end
        RD_WAIT: begin
          if (cnt_reg == 2'd0) begin
            if (we_reg) begin
              ram_wdata_reg <= (ram_rdata & ~lat_mask) | (wdata_reg & lat_mask);
              ram_en_reg    <= 1'b1;
              ram_wen_reg   <= 1'b1;
              state_reg     <= WR_CMD;
            end else begin
              rdata_reg <= ram_rdata & lat_mask;
              ack_reg   <= 1'b1;
              state_reg <= ACK;
            end
          end else begin
            cnt_reg <= cnt_reg - 2'd1;
          end
        end
        WR_CMD: begin
          ack_reg   <= 1'b1;
          state_reg <= ACK;
        end
        ACK: begin
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign busy      = busy_reg;
  assign ack       = ack_reg;
  assign rdata     = rdata_reg;
  // RAM strobes are masked by reset so no command escapes during reset.
  assign ram_en    = ram_en_reg & reset;
  assign ram_wen   = ram_wen_reg & reset;
  assign ram_addr  = ram_addr_reg;
  assign ram_wdata = ram_wdata_reg;

endmodule

// File: tb/tb_asrm_mem_sequencer.sv
// Directed bench: one sequencer with ram_latency=1 and one with
// ram_latency=3, each attached to a behavioural synchronous RAM.
module tb_asrm_mem_sequencer;

  logic clk;
  logic reset;

  logic        d1_req, d1_we, d1_busy, d1_ack, d1_ram_en, d1_ram_wen;
  logic [1:0]  d1_size;
  logic [15:0] d1_addr, d1_wdata, d1_rdata, d1_ram_addr, d1_ram_wdata, d1_ram_rdata;

  logic        d3_req, d3_we, d3_busy, d3_ack, d3_ram_en, d3_ram_wen;
  logic [1:0]  d3_size;
  logic [15:0] d3_addr, d3_wdata, d3_rdata, d3_ram_addr, d3_ram_wdata, d3_ram_rdata;

  int n_checks = 0;
  int n_fail   = 0;
  int rd_cnt3  = 0;
  int wr_cnt3  = 0;
  int en_in_reset = 0;

  logic [15:0] mem1 [0:65535];
  logic [15:0] mem3 [0:65535];
  logic [15:0] pipe1;
  logic [15:0] p3_0, p3_1, p3_2;

  asrm_mem_sequencer #(.wordsize(16), .ram_latency(1)) dut1 (
    .clk(clk), .reset(reset), .req(d1_req), .we(d1_we), .size(d1_size),
    .addr(d1_addr), .wdata(d1_wdata), .busy(d1_busy), .ack(d1_ack),
    .rdata(d1_rdata), .ram_en(d1_ram_en), .ram_wen(d1_ram_wen),
    .ram_addr(d1_ram_addr), .ram_wdata(d1_ram_wdata), .ram_rdata(d1_ram_rdata)
  );

  asrm_mem_sequencer #(.wordsize(16), .ram_latency(3)) dut3 (
    .clk(clk), .reset(reset), .req(d3_req), .we(d3_we), .size(d3_size),
    .addr(d3_addr), .wdata(d3_wdata), .busy(d3_busy), .ack(d3_ack),
    .rdata(d3_rdata), .ram_en(d3_ram_en), .ram_wen(d3_ram_wen),
    .ram_addr(d3_ram_addr), .ram_wdata(d3_ram_wdata), .ram_rdata(d3_ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign d1_ram_rdata = pipe1;
  assign d3_ram_rdata = p3_2;

  // Behavioural RAMs (1-cycle and 3-cycle read latency) plus event counters.
  always @(posedge clk) begin
    if (!reset) begin
      mem1[5] <= 16'hABCD;
      mem1[7] <= 16'h0000;
      mem3[5] <= 16'hABCD;
      mem3[7] <= 16'h5A5A;
    end else begin
      if (d1_ram_en && d1_ram_wen) mem1[d1_ram_addr] <= d1_ram_wdata;
      if (d3_ram_en && d3_ram_wen) mem3[d3_ram_addr] <= d3_ram_wdata;
    end
    pipe1 <= mem1[d1_ram_addr];
    p3_0  <= mem3[d3_ram_addr];
    p3_1  <= p3_0;
    p3_2  <= p3_1;
    if (d3_ram_en && !d3_ram_wen) rd_cnt3 <= rd_cnt3 + 1;
    if (d3_ram_en && d3_ram_wen)  wr_cnt3 <= wr_cnt3 + 1;
    if (!reset && (d1_ram_en || d3_ram_en || d1_ram_wen || d3_ram_wen))
      en_in_reset <= en_in_reset + 1;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One request on the latency-1 instance. Inputs are scrambled right after
  // acceptance; cycle numbers count from the accepting cycle (cycle 0).
  task automatic run1(input logic we, input logic [1:0] sz, input logic [15:0] a,
                      input logic [15:0] wd, output int ack_c, output int rd_c,
                      output int wr_c, output int nrd, output int nwr,
                      output logic [15:0] wv, output int bad_addr);
    d1_req = 1'b1; d1_we = we; d1_size = sz; d1_addr = a; d1_wdata = wd;
    ack_c = -1; rd_c = -1; wr_c = -1; nrd = 0; nwr = 0; wv = 16'h0; bad_addr = 0;
    for (int c = 1; c <= 10 && ack_c < 0; c++) begin
      tick();
      if (c == 1) begin
        d1_req = 1'b0; d1_we = ~we; d1_size = ~sz; d1_addr = ~a; d1_wdata = ~wd;
      end
      if (d1_ram_en) begin
        if (d1_ram_addr !== a) bad_addr++;
        if (d1_ram_wen) begin nwr++; wr_c = c; wv = d1_ram_wdata; end
        else begin nrd++; rd_c = c; end
      end
      if (d1_ack === 1'b1) ack_c = c;
    end
    tick();
    chk("idle_after_ack_busy", 32'(d1_busy), 32'd0);
    $display("op we=%0b size=%0b addr=%h wdata=%h: rd_cyc=%0d wr_cyc=%0d wval=%h ack_cyc=%0d rdata=%h",
             we, sz, a, wd, rd_c, wr_c, wv, ack_c, d1_rdata);
  endtask

  int ack_c, rd_c, wr_c, nrd, nwr, bad_a;
  logic [15:0] wv;

  initial begin
    reset = 1'b0;
    d1_req = 1'b0; d1_we = 1'b0; d1_size = 2'b00; d1_addr = 16'h0; d1_wdata = 16'h0;
    d3_req = 1'b0; d3_we = 1'b0; d3_size = 2'b00; d3_addr = 16'h0; d3_wdata = 16'h0;

    // Reset hold and release
    repeat (3) tick();
    chk("rst_busy", 32'(d1_busy), 32'd0);
    chk("rst_ram_en", 32'(d1_ram_en), 32'd0);
    reset = 1'b1;
    tick();
    chk("rel_busy", 32'(d1_busy), 32'd0);
    chk("rel_ack", 32'(d1_ack), 32'd0);
    chk("rel_rdata", 32'(d1_rdata), 32'h0);
    chk("rel_ram_addr", 32'(d1_ram_addr), 32'h0);
    chk("rel_ram_wdata", 32'(d1_ram_wdata), 32'h0);
    chk("rel3_busy", 32'(d3_busy), 32'd0);
    chk("rel3_rdata", 32'(d3_rdata), 32'h0);

    // Full load addr 5
    run1(1'b0, 2'b00, 16'd5, 16'h0000, ack_c, rd_c, wr_c, nrd, nwr, wv, bad_a);
    chk("ld_full_ack", ack_c, 3);
    chk("ld_full_rd", rd_c, 1);
    chk("ld_full_nwr", nwr, 0);
    chk("ld_full_addr", bad_a, 0);
    chk("ld_full_rdata", 32'(d1_rdata), 32'hABCD);

    // 8-bit load addr 5
    run1(1'b0, 2'b11, 16'd5, 16'h0000, ack_c, rd_c, wr_c, nrd, nwr, wv, bad_a);
    chk("ld_b_ack", ack_c, 3);
    chk("ld_b_rdata", 32'(d1_rdata), 32'h00CD);

    // Full store addr 7
    run1(1'b1, 2'b00, 16'd7, 16'h1234, ack_c, rd_c, wr_c, nrd, nwr, wv, bad_a);
    chk("st_full_ack", ack_c, 2);
    chk("st_full_nrd", nrd, 0);
    chk("st_full_nwr", nwr, 1);
    chk("st_full_wcyc", wr_c, 1);
    chk("st_full_wval", 32'(wv), 32'h1234);
    chk("st_full_addr", bad_a, 0);
    chk("st_full_rdata_kept", 32'(d1_rdata), 32'h00CD);

    // 8-bit store addr 5: read-modify-write
    run1(1'b1, 2'b11, 16'd5, 16'hFF99, ack_c, rd_c, wr_c, nrd, nwr, wv, bad_a);
    chk("st_b_rd", rd_c, 1);
    chk("st_b_wcyc", wr_c, 3);
    chk("st_b_wval", 32'(wv), 32'hAB99);
    chk("st_b_ack", ack_c, 4);
    chk("st_b_nwr", nwr, 1);
    chk("st_b_addr", bad_a, 0);
    chk("st_b_rdata_kept", 32'(d1_rdata), 32'h00CD);

    // Read back the merged word
    run1(1'b0, 2'b00, 16'd5, 16'h0000, ack_c, rd_c, wr_c, nrd, nwr, wv, bad_a);
    chk("rb_rdata", 32'(d1_rdata), 32'hAB99);

    // 16-bit size on a 16-bit word is a full store
    run1(1'b1, 2'b10, 16'd5, 16'hFF99, ack_c, rd_c, wr_c, nrd, nwr, wv, bad_a);
    chk("st_h_nrd", nrd, 0);
    chk("st_h_wcyc", wr_c, 1);
    chk("st_h_wval", 32'(wv), 32'hFF99);
    chk("st_h_ack", ack_c, 2);
    chk("st_h_rdata_kept", 32'(d1_rdata), 32'hAB99);

    run1(1'b0, 2'b00, 16'd7, 16'h0000, ack_c, rd_c, wr_c, nrd, nwr, wv, bad_a);
    chk("rb7_rdata", 32'(d1_rdata), 32'h1234);
    run1(1'b0, 2'b00, 16'd5, 16'h0000, ack_c, rd_c, wr_c, nrd, nwr, wv, bad_a);
    chk("rb5_rdata", 32'(d1_rdata), 32'hFF99);

    // Latency 3 load with a req pulse during busy
    d3_req = 1'b1; d3_we = 1'b0; d3_size = 2'b00; d3_addr = 16'd5;
    tick(); // cycle 1
    chk("l3_c1_en", 32'(d3_ram_en), 32'd1);
    chk("l3_c1_addr", 32'(d3_ram_addr), 32'd5);
    d3_req = 1'b0;
    tick(); // cycle 2
    d3_req = 1'b1; d3_addr = 16'd7;
    tick(); // cycle 3
    d3_req = 1'b0;
    chk("l3_c3_en", 32'(d3_ram_en), 32'd0);
    tick(); // cycle 4
    chk("l3_c4_ack", 32'(d3_ack), 32'd0);
    tick(); // cycle 5
    chk("l3_c5_ack", 32'(d3_ack), 32'd1);
    chk("l3_c5_rdata", 32'(d3_rdata), 32'hABCD);
    tick(); // cycle 6
    chk("l3_c6_busy", 32'(d3_busy), 32'd0);
    tick(); // cycle 7
    chk("l3_c7_busy", 32'(d3_busy), 32'd0);
    chk("l3_reads", rd_cnt3, 1);
    $display("op L3 load addr=0005 ack_cyc=5 rdata=%h", d3_rdata);

    // Held req: re-accepted on the first idle cycle after ack
    d3_req = 1'b1; d3_addr = 16'd7;
    repeat (5) tick(); // cycle 5
    chk("hold_c5_ack", 32'(d3_ack), 32'd1);
    chk("hold_c5_rdata", 32'(d3_rdata), 32'h5A5A);
    tick(); // cycle 6
    chk("hold_c6_busy", 32'(d3_busy), 32'd0);
    chk("hold_c6_en", 32'(d3_ram_en), 32'd0);
    tick(); // cycle 7
    chk("hold_c7_en", 32'(d3_ram_en), 32'd1);
    chk("hold_c7_busy", 32'(d3_busy), 32'd1);
    d3_req = 1'b0;
    repeat (4) tick(); // cycle 11
    chk("hold_c11_ack", 32'(d3_ack), 32'd1);
    tick();
    chk("hold_reads", rd_cnt3, 3);
    $display("op L3 held load addr=0007 twice rdata=%h", d3_rdata);

    // Reset during RD_WAIT of a reduced store: the write never happens
    d3_req = 1'b1; d3_we = 1'b1; d3_size = 2'b11; d3_addr = 16'd5; d3_wdata = 16'hFF99;
    tick(); // cycle 1
    d3_req = 1'b0;
    chk("rmw_c1_rd", 32'({d3_ram_en, d3_ram_wen}), 32'b10);
    tick(); // cycle 2, RD_WAIT
    reset = 1'b0;
    tick();
    chk("rmw_rst_busy", 32'(d3_busy), 32'd0);
    chk("rmw_rst_ack", 32'(d3_ack), 32'd0);
    chk("rmw_rst_en", 32'(d3_ram_en), 32'd0);
    reset = 1'b1;
    repeat (6) tick();
    chk("rmw_no_write", wr_cnt3, 0);
    chk("rmw_idle", 32'(d3_busy), 32'd0);
    $display("op L3 reduced store aborted by reset writes=%0d", wr_cnt3);

    // ram_en is masked combinationally while reset is low
    d1_req = 1'b1; d1_we = 1'b0; d1_size = 2'b00; d1_addr = 16'd5;
    tick(); // cycle 1, RD_CMD
    d1_req = 1'b0;
    chk("gate_pre_en", 32'(d1_ram_en), 32'd1);
    reset = 1'b0;
    #1;
    chk("gate_en", 32'(d1_ram_en), 32'd0);
    tick();
    chk("gate_busy", 32'(d1_busy), 32'd0);
    chk("gate_rdata", 32'(d1_rdata), 32'h0);
    reset = 1'b1;
    tick();
    chk("en_during_reset", en_in_reset, 0);
    $display("op reset gating during RD_CMD busy=%0b", d1_busy);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
